axis_fifo: RTL and testbench

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo_pkg.sv | 32 +++
 rtl/axis_fifo_sp_ram.sv | 25 ++
 rtl/axis_fifo.sv | 140 ++++++++++++++
 tb/tb_axis_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared types and pointer helpers for the AXI-Stream FIFO.
// Pointers carry one extra wrap bit so full and empty can be told apart.
package axis_fifo_pkg;

  localparam int DEFAULT_ALEN  = 4;
  localparam int DEFAULT_DEPTH = 1 << DEFAULT_ALEN;
  localparam int MAX_ALEN      = 4;

  typedef logic [MAX_ALEN:0]     ptr_max_t;
  typedef logic [DEFAULT_ALEN:0] level_t;

  // Level must reach D itself, so it needs one bit more than an address.
  function automatic int level_width(input int alen);
    return alen + 1;
  endfunction

  // Full when the wrap bits differ and the address bits match.
  function automatic logic ptr_full(input ptr_max_t wp, input ptr_max_t rp, input int alen);
    ptr_max_t diff;
    ptr_max_t low_mask;
    ptr_max_t msb_mask;
    diff     = wp ^ rp;
    low_mask = ptr_max_t'((1 << alen) - 1);
    msb_mask = ptr_max_t'(1 << alen);
    return ((diff & msb_mask) != '0) && ((diff & low_mask) == '0);
  endfunction

  function automatic logic ptr_empty(input ptr_max_t wp, input ptr_max_t rp);
    return wp == rp;
  endfunction

endpackage

// File: rtl/axis_fifo_sp_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module sp_ram #(
  parameter int DLEN = 8,
  parameter int ALEN = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ALEN-1:0] waddr,
  input  logic [DLEN-1:0] wdata,
  input  logic [ALEN-1:0] raddr,
  output logic [DLEN-1:0] rdata
);

  logic [DLEN-1:0] mem [2**ALEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with an output register in front of the RAM.
// OUT_REG=0 delays write visibility by one cycle to model the direct RAM read path.
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DLEN    = 8,
  parameter int ALEN    = 4,
  parameter int OUT_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_wr_tvalid,
  output logic            o_wr_tready,
  input  logic [DLEN-1:0] i_wr_tdata,
  output logic            o_rd_tvalid,
  input  logic            i_rd_tready,
  output logic [DLEN-1:0] o_rd_tdata,
  output logic [ALEN:0]   o_level,
  input  logic [ALEN:0]   i_af_thresh,
  input  logic [ALEN:0]   i_ae_thresh,
  output logic            o_almost_full,
  output logic            o_almost_empty,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam int DEPTH = 1 << ALEN;
  localparam int LW    = level_width(ALEN);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [ALEN:0]   wptr;
  logic [ALEN:0]   rptr;
  logic [ALEN:0]   wptr_vis;
  logic [LW-1:0]   level;
  logic            out_valid;
  logic [DLEN-1:0] out_data;
  logic [DLEN-1:0] ram_rdata;
  logic            wr_fire;
  logic            ram_we;
  logic            rd_fire;
  logic            ram_full;
  logic            ram_empty;
  logic            load;
  logic            af;
  logic            ae;
  logic            ovf;
  logic            unf;

  // Ready depends only on the registered level and flush, never on the read side.
  assign o_wr_tready = (level < FULL_LEVEL) && !i_flush;
  assign wr_fire     = i_wr_tvalid && o_wr_tready;
  assign ram_full    = ptr_full(ptr_max_t'(wptr), ptr_max_t'(rptr), ALEN);
  assign ram_we      = wr_fire && !ram_full;
  assign rd_fire     = out_valid && i_rd_tready;
  assign ram_empty   = ptr_empty(ptr_max_t'(wptr_vis), ptr_max_t'(rptr));
  assign load        = (!out_valid || rd_fire) && !ram_empty;

  if (OUT_REG != 0) begin : g_skid
    assign wptr_vis = wptr;
  end else begin : g_direct
    logic [ALEN:0] wptr_d;
    always_ff @(posedge clk) begin
      if (rst || i_flush) begin
        wptr_d <= '0;
      end else begin
        wptr_d <= wptr;
      end
    end
    assign wptr_vis = wptr_d;
  end

  sp_ram #(
    .DLEN(DLEN),
    .ALEN(ALEN)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wptr[ALEN-1:0]),
    .wdata(i_wr_tdata),
    .raddr(rptr[ALEN-1:0]),
    .rdata(ram_rdata)
  );

  // Output register refills in the same cycle it is consumed, keeping full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (i_flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (ram_we) begin
        wptr <= wptr + (ALEN+1)'(1);
      end
      if (load) begin
        out_data  <= ram_rdata;
        out_valid <= 1'b1;
        rptr      <= rptr + (ALEN+1)'(1);
      end else if (rd_fire) begin
        out_valid <= 1'b0;
      end
      level <= level + LW'(ram_we) - LW'(rd_fire);
    end
  end

  // Threshold flags lag the level by one cycle; error flags stick until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      af  <= 1'b0;
      ae  <= 1'b1;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      af <= (level >= i_af_thresh);
      ae <= (level <= i_ae_thresh);
      if (i_wr_tvalid && (level == FULL_LEVEL)) begin
        ovf <= 1'b1;
      end
      if (i_rd_tready && !out_valid) begin
        unf <= 1'b1;
      end
    end
  end

  assign o_rd_tvalid    = out_valid;
  assign o_rd_tdata     = out_data;
  assign o_level        = level;
  assign o_almost_full  = af;
  assign o_almost_empty = ae;
  assign o_overflow     = ovf;
  assign o_underflow    = unf;

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: both OUT_REG variants driven in parallel and checked every
// cycle against a queue model in which a word becomes visible a fixed latency after its write.
module tb_axis_fifo;

  localparam int DLEN  = 8;
  localparam int ALEN  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst      = 1'b1;
  logic            flush    = 1'b0;
  logic            wr_valid = 1'b0;
  logic            rd_ready = 1'b0;
  logic [7:0]      wr_data  = '0;
  logic [ALEN:0]   af_th    = 3'd3;
  logic [ALEN:0]   ae_th    = 3'd1;
  logic [1:0]      wr_ready, rd_valid, af, ae, ovf, unf;
  logic [7:0]      rd_data [2];
  logic [ALEN:0]   level [2];

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [7:0] fill_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  axis_fifo #(.DLEN(DLEN), .ALEN(ALEN), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_wr_tvalid(wr_valid), .o_wr_tready(wr_ready[0]), .i_wr_tdata(wr_data),
    .o_rd_tvalid(rd_valid[0]), .i_rd_tready(rd_ready), .o_rd_tdata(rd_data[0]),
    .o_level(level[0]), .i_af_thresh(af_th), .i_ae_thresh(ae_th),
    .o_almost_full(af[0]), .o_almost_empty(ae[0]),
    .o_overflow(ovf[0]), .o_underflow(unf[0])
  );

  axis_fifo #(.DLEN(DLEN), .ALEN(ALEN), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_wr_tvalid(wr_valid), .o_wr_tready(wr_ready[1]), .i_wr_tdata(wr_data),
    .o_rd_tvalid(rd_valid[1]), .i_rd_tready(rd_ready), .o_rd_tdata(rd_data[1]),
    .o_level(level[1]), .i_af_thresh(af_th), .i_ae_thresh(ae_th),
    .o_almost_full(af[1]), .o_almost_empty(ae[1]),
    .o_overflow(ovf[1]), .o_underflow(unf[1])
  );

  // Reference model: circular queue per instance, each word tagged with its write edge.
  int         m_cnt  [2] = '{0, 0};
  int         m_head [2] = '{0, 0};
  logic [7:0] m_data [2][16];
  int         m_edge [2][16];
  logic       m_af   [2] = '{1'b0, 1'b0};
  logic       m_ae   [2] = '{1'b1, 1'b1};
  logic       m_ovf  [2] = '{1'b0, 1'b0};
  logic       m_unf  [2] = '{1'b0, 1'b0};
  int         edge_no = 0;

  function automatic int lat(input int i);
    return (i == 1) ? 1 : 2;
  endfunction

  function automatic logic m_valid(input int i);
    if (m_cnt[i] == 0) return 1'b0;
    return (m_edge[i][m_head[i]] + lat(i)) <= edge_no;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic vld;
      logic rdy;
      int   idx;
      vld = m_valid(i);
      rdy = (m_cnt[i] < DEPTH) && !flush;
      if (rst) begin
        m_cnt[i]  = 0;
        m_head[i] = 0;
        m_af[i]   = 1'b0;
        m_ae[i]   = 1'b1;
        m_ovf[i]  = 1'b0;
        m_unf[i]  = 1'b0;
      end else begin
        if (wr_valid && m_cnt[i] == DEPTH) m_ovf[i] = 1'b1;
        if (rd_ready && !vld) m_unf[i] = 1'b1;
        m_af[i] = m_cnt[i] >= int'(af_th);
        m_ae[i] = m_cnt[i] <= int'(ae_th);
        if (flush) begin
          m_cnt[i]  = 0;
          m_head[i] = 0;
        end else begin
          if (vld && rd_ready) begin
            m_head[i] = (m_head[i] + 1) % 16;
            m_cnt[i]  = m_cnt[i] - 1;
          end
          if (wr_valid && rdy) begin
            idx = (m_head[i] + m_cnt[i]) % 16;
            m_data[i][idx] = wr_data;
            m_edge[i][idx] = edge_no + 1;
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
    edge_no = edge_no + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("level[%0d]", i), int'(level[i]), m_cnt[i]);
        checkOutput($sformatf("wr_tready[%0d]", i), int'(wr_ready[i]),
                    int'((m_cnt[i] < DEPTH) && !flush));
        checkOutput($sformatf("rd_tvalid[%0d]", i), int'(rd_valid[i]), int'(m_valid(i)));
        if (m_valid(i))
          checkOutput($sformatf("rd_tdata[%0d]", i), int'(rd_data[i]), int'(m_data[i][m_head[i]]));
        checkOutput($sformatf("almost_full[%0d]", i), int'(af[i]), int'(m_af[i]));
        checkOutput($sformatf("almost_empty[%0d]", i), int'(ae[i]), int'(m_ae[i]));
        checkOutput($sformatf("overflow[%0d]", i), int'(ovf[i]), int'(m_ovf[i]));
        checkOutput($sformatf("underflow[%0d]", i), int'(unf[i]), int'(m_unf[i]));
      end
    end
  end

  // Drive inputs now; return 1ns after the edge that consumes them.
  task automatic applyStimulus(input logic r, input logic wv, input logic [7:0] wd,
                               input logic rr, input logic fl);
    rst      = r;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r, wv, rr, fl;

    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_level", int'(level[1]), 0);
    checkOutput("reset_wr_tready", int'(wr_ready[1]), 1);
    checkOutput("reset_rd_tvalid", int'(rd_valid[1]), 0);
    checkOutput("reset_rd_tdata0", int'(rd_data[0]), 0);
    checkOutput("reset_rd_tdata1", int'(rd_data[1]), 0);
    checkOutput("reset_almost_full", int'(af[1]), 0);
    checkOutput("reset_almost_empty", int'(ae[1]), 1);
    checkOutput("reset_overflow", int'(ovf[1]), 0);
    checkOutput("reset_underflow", int'(unf[0]), 0);

    // Latency: one edge to valid with the output register, two without.
    applyStimulus(0, 1, 8'hA5, 0, 0);
    checkOutput("lat_n_valid1", int'(rd_valid[1]), 0);
    checkOutput("lat_n_level1", int'(level[1]), 1);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("lat_n1_valid1", int'(rd_valid[1]), 1);
    checkOutput("lat_n1_data1", int'(rd_data[1]), 8'hA5);
    checkOutput("lat_n1_valid0", int'(rd_valid[0]), 0);
    checkOutput("lat_n1_model0", int'(m_valid(0)), 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("lat_n2_valid0", int'(rd_valid[0]), 1);
    checkOutput("lat_n2_data0", int'(rd_data[0]), 8'hA5);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("lat_drained", int'(level[0]) + int'(level[1]), 0);

    // Fill to capacity, then one write too many.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, fill_vals[k], 0, 0);
      if (k == 2) begin
        checkOutput("fill3_level", int'(level[1]), 3);
        checkOutput("fill3_af_lags", int'(af[1]), 0);
      end
    end
    checkOutput("fill_level", int'(level[1]), 4);
    checkOutput("fill_model_level", m_cnt[1], 4);
    checkOutput("fill_wr_tready", int'(wr_ready[1]), 0);
    checkOutput("fill_af", int'(af[1]), 1);
    applyStimulus(0, 1, 8'h55, 0, 0);
    checkOutput("fill_overflow", int'(ovf[1]), 1);
    checkOutput("fill_overflow0", int'(ovf[0]), 1);
    checkOutput("fill_level_after_ovf", int'(level[1]), 4);

    // Drain in write order; 0x55 must never appear.
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("drain_data1_%0d", k), int'(rd_data[1]), int'(fill_vals[k]));
      checkOutput($sformatf("drain_data0_%0d", k), int'(rd_data[0]), int'(fill_vals[k]));
      applyStimulus(0, 0, 8'h00, 1, 0);
      if (k == 2) begin
        checkOutput("drain_level1", int'(level[1]), 1);
        checkOutput("drain_ae_lags", int'(ae[1]), 0);
      end
    end
    checkOutput("drain_ae", int'(ae[1]), 1);
    checkOutput("drain_empty_valid", int'(rd_valid[1]), 0);
    checkOutput("drain_underflow_before", int'(unf[1]), 0);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("drain_underflow", int'(unf[1]), 1);
    checkOutput("drain_model_underflow", int'(m_unf[1]), 1);

    // Flush with a concurrent write.
    applyStimulus(0, 1, 8'h61, 0, 0);
    applyStimulus(0, 1, 8'h62, 0, 0);
    applyStimulus(0, 1, 8'h63, 0, 0);
    checkOutput("preflush_level", int'(level[1]), 3);
    applyStimulus(0, 1, 8'h99, 0, 1);
    checkOutput("flush_level", int'(level[1]), 0);
    checkOutput("flush_level0", int'(level[0]), 0);
    checkOutput("flush_valid", int'(rd_valid[1]), 0);
    checkOutput("flush_overflow_kept", int'(ovf[1]), 1);
    checkOutput("flush_underflow_kept", int'(unf[1]), 1);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("flush_write_dropped", int'(rd_valid[1]) + int'(level[1]), 0);

    // Streaming: 40 words through a 4-deep FIFO, pointers wrap five times.
    for (int k = 0; k < 40; k++) begin
      applyStimulus(0, 1, 8'(k * 7 + 3), 1, 0);
      if (k == 20) begin
        checkOutput("stream_level1", int'(level[1]), 2);
        checkOutput("stream_level0", int'(level[0]), 3);
        checkOutput("stream_model_level1", m_cnt[1], 2);
      end
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 1, 0);

    // Random traffic with occasional flush, reset and threshold changes.
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 99) < 1);
      wv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0) begin
        af_th = 3'($urandom_range(0, 7));
        ae_th = 3'($urandom_range(0, 7));
      end
      applyStimulus(r, wv, 8'($urandom), rr, fl);
    end
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("final_level", int'(level[1]), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
